// File: rtl/conv_enc_pkg.sv
// Shared types and helpers for the convolutional encoder and the decoder
// blocks that reuse its branch logic.
package conv_enc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StTail
   } state_e;

   // Classic K=3, rate-1/2 trellis: generator 0 in the MSBs
   localparam logic [5:0] G_K3_R2 = {3'b111, 3'b101};

   function automatic logic parity(input logic [31:0] vec);
      return ^vec;
   endfunction

endpackage

// File: rtl/conv_enc_branch.sv
// Combinational branch-symbol generator: maps {input, shift register} to the
// N parity bits of the configured generators.
module conv_enc_branch
   import conv_enc_pkg::*;
#(
   parameter int unsigned    K = 3,
   parameter int unsigned    N = 2,
   parameter logic [N*K-1:0] G = G_K3_R2
) (
   input  logic [K-1:0] i_v,
   output logic [N-1:0] o_sym
);

   // Generator j sits at slice N-1-j and drives symbol bit N-1-j
   always_comb begin
      o_sym = '0;
      for (int i = 0; i < int'(N); i++) begin
         o_sym[i] = parity(32'(G[i*K +: K] & i_v));
      end
   end

endmodule

// File: rtl/conv_encoder.sv
// Framed rate-1/N feed-forward convolutional encoder with optional zero-tail
// termination and valid/ready handshakes on both sides.
module conv_encoder
   import conv_enc_pkg::*;
#(
   parameter int unsigned    K     = 3,
   parameter int unsigned    N     = 2,
   parameter logic [N*K-1:0] G     = G_K3_R2,
   parameter int unsigned    LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_frame_len,
   input  logic             i_tail_en,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic             i_in_bit,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [N-1:0]     o_out_sym,
   output logic             o_out_last,
   output logic             o_busy
);

   state_e           r_state;
   logic [K-2:0]     r_sr;
   logic [LEN_W-1:0] r_cnt;
   logic             r_tail_en;
   logic [3:0]       r_tail_cnt;
   logic             r_out_valid;
   logic [N-1:0]     r_out_sym;
   logic             r_out_last;

   logic             w_free;
   logic             w_pop;
   logic             w_in;
   logic [K-1:0]     w_v;
   logic [K-2:0]     w_sr_next;
   logic [N-1:0]     w_sym;

   assign w_pop     = r_out_valid && i_out_ready;
   assign w_free    = !r_out_valid || i_out_ready;
   assign w_in      = (r_state == StTail) ? 1'b0 : i_in_bit;
   assign w_v       = {w_in, r_sr};
   assign w_sr_next = {w_in, r_sr[K-2:1]};

   conv_enc_branch #(
      .K (K),
      .N (N),
      .G (G)
   ) u_branch (
      .i_v   (w_v),
      .o_sym (w_sym)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_tail_en   <= 1'b0;
         r_tail_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_sym   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         // A load below overrides this pop in the same cycle
         if (w_pop) begin
            r_out_valid <= 1'b0;
         end
         unique case (r_state)
            StIdle: begin
               if (i_start && (i_frame_len != '0) && !r_out_valid) begin
                  r_sr      <= '0;
                  r_cnt     <= i_frame_len;
                  r_tail_en <= i_tail_en;
                  r_state   <= StData;
               end
            end
            StData: begin
               if (i_in_valid && w_free) begin
                  r_out_valid <= 1'b1;
                  r_out_sym   <= w_sym;
                  r_out_last  <= 1'b0;
                  r_sr        <= w_sr_next;
                  r_cnt       <= r_cnt - LEN_W'(1);
                  if (r_cnt == LEN_W'(1)) begin
                     if (r_tail_en) begin
                        r_tail_cnt <= 4'(K - 2);
                        r_state    <= StTail;
                     end else begin
                        r_out_last <= 1'b1;
                        r_state    <= StIdle;
                     end
                  end
               end
            end
            StTail: begin
               if (w_free) begin
                  r_out_valid <= 1'b1;
                  r_out_sym   <= w_sym;
                  r_sr        <= w_sr_next;
                  if (r_tail_cnt == '0) begin
                     r_out_last <= 1'b1;
                     r_state    <= StIdle;
                  end else begin
                     r_out_last <= 1'b0;
                     r_tail_cnt <= r_tail_cnt - 4'd1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_in_ready  = (r_state == StData) && w_free;
   assign o_out_valid = r_out_valid;
   assign o_out_sym   = r_out_sym;
   assign o_out_last  = r_out_last;
   assign o_busy      = (r_state != StIdle) || r_out_valid;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: default K=3 rate-1/2 instance plus a K=7 instance,
// both checked against a convolution-sum reference model.
module tb_conv_encoder;

   logic       clk;
   logic       rst_n;

   logic       a_start, a_tail, a_iv, a_ir, a_bit, a_ov, a_or, a_last, a_busy;
   logic [7:0] a_len;
   logic [1:0] a_sym;

   logic       b_start, b_tail, b_iv, b_ir, b_bit, b_ov, b_or, b_last, b_busy;
   logic [7:0] b_len;
   logic [1:0] b_sym;

   int n_tests = 0;
   int n_fail  = 0;

   bit bits_q[$];
   int exp_q[$];

   conv_encoder u_dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (a_start),
      .i_frame_len (a_len),
      .i_tail_en   (a_tail),
      .i_in_valid  (a_iv),
      .o_in_ready  (a_ir),
      .i_in_bit    (a_bit),
      .o_out_valid (a_ov),
      .i_out_ready (a_or),
      .o_out_sym   (a_sym),
      .o_out_last  (a_last),
      .o_busy      (a_busy)
   );

   conv_encoder #(
      .K     (7),
      .N     (2),
      .G     ({7'o171, 7'o133}),
      .LEN_W (8)
   ) u_dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (b_start),
      .i_frame_len (b_len),
      .i_tail_en   (b_tail),
      .i_in_valid  (b_iv),
      .o_in_ready  (b_ir),
      .i_in_bit    (b_bit),
      .o_out_valid (b_ov),
      .i_out_ready (b_or),
      .o_out_sym   (b_sym),
      .o_out_last  (b_last),
      .o_busy      (b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // y_j[t] = XOR_d g_j[K-1-d] & u[t-d], with u = 0 outside the data bits
   task automatic build_expected(input int k, input int n, input logic [63:0] g,
                                 input bit tail);
      int total;
      logic [63:0] gj;
      int sym;
      bit p;
      exp_q.delete();
      total = bits_q.size() + (tail ? k - 1 : 0);
      for (int t = 0; t < total; t++) begin
         sym = 0;
         for (int j = 0; j < n; j++) begin
            gj = (g >> ((n - 1 - j) * k)) & ((64'd1 << k) - 64'd1);
            p  = 1'b0;
            for (int d = 0; d < k; d++) begin
               if (t - d >= 0 && t - d < bits_q.size()) begin
                  p = p ^ (gj[k-1-d] & bits_q[t-d]);
               end
            end
            sym = sym | (int'(p) << (n - 1 - j));
         end
         exp_q.push_back(sym);
      end
   endtask

   // mode 0: always ready/valid; 1: random gaps; 2: out_ready low for cycles 3..5
   task automatic run_a(input int mode, input bit tail, input bit spurious,
                        input int abort_after);
      int idx = 0, got = 0, cyc = 0;
      bit stalled = 1'b0;
      logic [1:0] held_sym = '0;
      logic held_last = 1'b0;
      @(negedge clk);
      a_start = 1'b1;
      a_len   = 8'(bits_q.size());
      a_tail  = tail;
      @(posedge clk);
      #1;
      a_start = 1'b0;
      while (got < exp_q.size() && cyc < 2000) begin
         if (mode == 0)      a_or = 1'b1;
         else if (mode == 1) a_or = ($urandom_range(0, 3) != 0);
         else                a_or = !(cyc >= 3 && cyc <= 5);
         a_iv  = (idx < bits_q.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
         a_bit = (idx < bits_q.size()) ? bits_q[idx] : 1'b0;
         a_start = spurious && (cyc == 1);
         if (a_start) a_len = 8'd5;
         @(negedge clk);
         if (stalled) begin
            n_tests++;
            if (a_ov !== 1'b1 || a_sym !== held_sym || a_last !== held_last) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%b sym=%b last=%b, want v=1 sym=%b last=%b",
                        a_ov, a_sym, a_last, held_sym, held_last);
            end
         end
         if (a_ov && !a_or) begin
            n_tests++;
            if (a_ir !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_in_ready: got %b, want 0", a_ir);
            end
            stalled   = 1'b1;
            held_sym  = a_sym;
            held_last = a_last;
         end else begin
            stalled = 1'b0;
         end
         if (a_iv && a_ir) idx++;
         if (a_ov && a_or) begin
            n_tests++;
            if (a_sym !== exp_q[got][1:0] || a_last !== (got == exp_q.size() - 1)) begin
               n_fail++;
               $display("FAIL symbol[%0d]: got sym=%b last=%b, want sym=%b last=%b", got,
                        a_sym, a_last, exp_q[got][1:0], (got == exp_q.size() - 1));
            end
            got++;
            if (abort_after > 0 && got == abort_after) break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      a_start = 1'b0;
      if (abort_after == 0) begin
         n_tests++;
         if (got != exp_q.size()) begin
            n_fail++;
            $display("FAIL frame_timeout: got %0d symbols, want %0d", got, exp_q.size());
         end
         a_iv = 1'b0;
         a_or = 1'b1;
         @(negedge clk);
         n_tests++;
         if (a_busy !== 1'b0 || a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_frame: got busy=%b valid=%b, want 0 0", a_busy, a_ov);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if ({a_ov, a_sym, a_last, a_ir, a_busy} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_values: got v=%b sym=%b last=%b rdy=%b busy=%b, want all 0",
                  a_ov, a_sym, a_last, a_ir, a_busy);
      end
   endtask

   task automatic test_spec_tail();
      bits_q = '{0, 1, 1, 1, 0, 0};
      exp_q  = '{0, 3, 1, 2, 1, 3, 0, 0};
      run_a(0, 1'b1, 1'b0, 0);
   endtask

   task automatic test_spec_no_tail();
      bits_q = '{0, 1, 1, 1, 0, 0};
      exp_q  = '{0, 3, 1, 2, 1, 3};
      run_a(0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_short_frame();
      bits_q = '{1};
      exp_q  = '{3, 2, 3};
      run_a(0, 1'b1, 1'b0, 0);
   endtask

   task automatic test_stall();
      for (int r = 0; r < 6; r++) begin
         bit tail;
         bits_q.delete();
         for (int i = 0; i < 20 + int'($urandom_range(0, 20)); i++)
            bits_q.push_back(1'($urandom));
         tail = 1'($urandom);
         build_expected(3, 2, 64'b111101, tail);
         run_a((r < 2) ? 2 : 1, tail, 1'b0, 0);
      end
   endtask

   task automatic test_reset_mid();
      bits_q.delete();
      for (int i = 0; i < 10; i++) bits_q.push_back(1'($urandom));
      build_expected(3, 2, 64'b111101, 1'b1);
      run_a(0, 1'b1, 1'b0, 3);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({a_ov, a_sym, a_last, a_ir, a_busy} !== 6'b0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b sym=%b last=%b rdy=%b busy=%b, want all 0",
                  a_ov, a_sym, a_last, a_ir, a_busy);
      end
      a_iv = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      test_spec_tail();
   endtask

   task automatic test_ignored_start();
      @(negedge clk);
      a_start = 1'b1;
      a_len   = 8'd0;
      a_tail  = 1'b1;
      @(posedge clk);
      #1;
      a_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (a_busy !== 1'b0 || a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_start: got busy=%b valid=%b, want 0 0", a_busy, a_ov);
         end
      end
      bits_q.delete();
      for (int i = 0; i < 3; i++) bits_q.push_back(1'($urandom));
      build_expected(3, 2, 64'b111101, 1'b0);
      run_a(0, 1'b0, 1'b1, 0);
   endtask

   task automatic test_k7_random();
      int idx = 0, got = 0, cyc = 0;
      bits_q.delete();
      for (int i = 0; i < 64; i++) bits_q.push_back(1'($urandom));
      build_expected(7, 2, 64'({7'o171, 7'o133}), 1'b1);
      @(negedge clk);
      b_start = 1'b1;
      b_len   = 8'd64;
      b_tail  = 1'b1;
      @(posedge clk);
      #1;
      b_start = 1'b0;
      while (got < exp_q.size() && cyc < 2000) begin
         b_or  = ($urandom_range(0, 3) != 0);
         b_iv  = (idx < 64) && ($urandom_range(0, 3) != 0);
         b_bit = (idx < 64) ? bits_q[idx] : 1'b0;
         @(negedge clk);
         if (b_iv && b_ir) idx++;
         if (b_ov && b_or) begin
            n_tests++;
            if (b_sym !== exp_q[got][1:0] || b_last !== (got == exp_q.size() - 1)) begin
               n_fail++;
               $display("FAIL k7_symbol[%0d]: got sym=%b last=%b, want sym=%b last=%b", got,
                        b_sym, b_last, exp_q[got][1:0], (got == exp_q.size() - 1));
            end
            got++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      n_tests++;
      if (got != exp_q.size()) begin
         n_fail++;
         $display("FAIL k7_timeout: got %0d symbols, want %0d", got, exp_q.size());
      end
      b_iv = 1'b0;
      b_or = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      a_start = 1'b0; a_len = '0; a_tail = 1'b0; a_iv = 1'b0; a_bit = 1'b0; a_or = 1'b1;
      b_start = 1'b0; b_len = '0; b_tail = 1'b0; b_iv = 1'b0; b_bit = 1'b0; b_or = 1'b1;
      repeat (2) @(posedge clk);
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_spec_tail();
      test_spec_no_tail();
      test_short_frame();
      test_stall();
      test_reset_mid();
      test_ignored_start();
      test_k7_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
